apb_cmd_master: RTL and testbench



---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_cmd_master_if.sv | 46 ++++
 rtl/apb_wait_timer.sv | 38 +++
 rtl/apb_cmd_master.sv | 142 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: FSM encoding, alignment mask,
// default ACCESS timeout and a word-alignment helper.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Bundles the command stream, response stream and APB3 bus of apb_cmd_master.
// The master modport is the initiator's view; slave is the sequencer/slave side.
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter for apb_cmd_master (built only with APB_CMD_MASTER_TIMEOUT_EN).
// expire pulses on the PREADY-low cycle whose increment would reach TIMEOUT_CYCLES.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag fires on the edge the count reaches the limit, so the FSM aborts on that same edge.
  assign expire = inc && (count_q == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns a valid/ready command stream into single SETUP/ACCESS transfers
// and returns data/error on a valid/ready response stream. Optional: APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input logic              PCLK,
  input logic              PRESETn,
  apb_cmd_master_if.master bus
);

  logic [1:0]            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  timeout_hit;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clear (state_q == ST_SETUP),
    .inc   ((state_q == ST_ACCESS) && !bus.PREADY),
    .expire(timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (is_aligned(bus.cmd_addr[1:0])) begin
            psel_d   = 1'b1;
            pwrite_d = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            pwdata_d = bus.cmd_wdata;
            state_d  = ST_SETUP;
          end else begin
            // Misaligned: answer with an error without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = ST_RESP;
          end
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.PSLVERR;
          rsp_rdata_d = (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
          state_d     = ST_RESP;
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed vector table, reset/timeout sequences and random
// commands against a transaction-level model with a memory-backed APB slave.
module tb_apb_cmd_master;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;
  localparam int unsigned NV  = 10;

  logic        PCLK    = 1'b0;
  logic        PRESETn = 1'b0;
  int unsigned cyc     = 0;
  int unsigned n_cmp   = 0;
  int unsigned n_fail  = 0;

  logic [31:0] slave_mem [1024];
  logic [31:0] ref_mem   [1024];

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wd;
    int unsigned waits;
    logic        serr;
    int unsigned hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_lat;
    int unsigned exp_psel;
  } vec_t;

  vec_t vecs [NV];

  apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_cmd_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Transaction-level expectation: misaligned -> immediate error; timed out -> error after
  // TMO wait cycles; otherwise 3 + waits cycles with slave data/error.
  function automatic void model(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                                input int unsigned waits, input logic serr,
                                output logic [31:0] e_rd, output logic e_err,
                                output int unsigned e_lat, output int unsigned e_psel);
    bit aligned;
    bit tout;
    aligned = (addr[1:0] == 2'b00);
    tout    = 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    tout = aligned && (waits >= TMO);
`endif
    e_err = !aligned || tout || serr;
    e_rd  = (!e_err && !wr) ? ref_mem[addr[11:2]] : 32'h0;
    if (!aligned) begin
      e_lat = 1; e_psel = 0;
    end else if (tout) begin
      e_lat = 2 + TMO; e_psel = 1 + TMO;
    end else begin
      e_lat = 3 + waits; e_psel = 2 + waits;
    end
    if (aligned && !tout && wr && !serr) ref_mem[addr[11:2]] = wd;
  endfunction

  task automatic noise_cmd();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = 12'($urandom);
    bus.cmd_wdata = $urandom;
  endtask

  task automatic run_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                         input int unsigned waits, input logic serr, input int unsigned hold,
                         output logic [31:0] r_rd, output logic r_err, output int unsigned lat,
                         output int unsigned n_psel, output int unsigned n_pen,
                         output int unsigned acc_cyc, output int unsigned hs_cyc);
    int unsigned k, acc, h;
    bit done, seen;
    k = 0; acc = 0; h = 0; done = 0; seen = 0;
    r_rd = '0; r_err = 1'b0; lat = 0; n_psel = 0; n_pen = 0; hs_cyc = 0;
    @(negedge PCLK);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_rsp_valid", bus.rsp_valid, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.rsp_ready = (hold == 0);
    @(posedge PCLK); #1;
    acc_cyc = cyc;
    while (!done && k < 100) begin
      @(negedge PCLK);
      k++;
      chk("busy_cmd_ready", bus.cmd_ready, 0);
      chk("penable_needs_psel", 32'(bus.PENABLE & ~bus.PSEL), 0);
      bus.PREADY  = 1'($urandom_range(0, 1));
      bus.PSLVERR = 1'($urandom_range(0, 1));
      bus.PRDATA  = $urandom;
      if (bus.PSEL) begin
        n_psel++;
        chk("paddr_stable", 32'(bus.PADDR), 32'(addr));
        chk("pwrite_stable", 32'(bus.PWRITE), 32'(wr));
        if (wr) chk("pwdata_stable", bus.PWDATA, wd);
        if (bus.PENABLE) begin
          n_pen++;
          acc++;
          if (acc > waits) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = serr;
            if (!wr && !serr) bus.PRDATA = slave_mem[bus.PADDR[11:2]];
            if (wr && !serr) slave_mem[bus.PADDR[11:2]] = bus.PWDATA;
          end else begin
            bus.PREADY = 1'b0;
          end
        end
      end
      if (bus.rsp_valid) begin
        if (!seen) begin
          seen  = 1;
          lat   = k;
          r_rd  = bus.rsp_rdata;
          r_err = bus.rsp_err;
        end else begin
          chk("rsp_rdata_hold", bus.rsp_rdata, r_rd);
          chk("rsp_err_hold", 32'(bus.rsp_err), 32'(r_err));
        end
        chk("resp_psel_low", 32'(bus.PSEL | bus.PENABLE), 0);
        if (!bus.rsp_ready) begin
          h++;
          if (h > hold) bus.rsp_ready = 1'b1;
        end
        if (bus.rsp_ready) begin
          bus.cmd_valid = 1'b0;
          @(posedge PCLK); #1;
          hs_cyc = cyc;
          done   = 1;
        end else begin
          noise_cmd();
        end
      end else begin
        noise_cmd();
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_wait_budget: no handshake after %0d cycles, required one", k);
      bus.cmd_valid = 1'b0;
    end
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, e_rd;
    logic        er, e_err;
    int unsigned lat, np, ne, ac, hs, prev_hs, e_lat, e_psel;
    bit          have_prev;

    for (int i = 0; i < 1024; i++) begin
      slave_mem[i] = 32'h1000_0000 + 32'(i);
      ref_mem[i]   = 32'h1000_0000 + 32'(i);
    end
    slave_mem[1] = 32'h0000_0123;
    ref_mem[1]   = 32'h0000_0123;

    //          wr    addr     wdata          wt serr hold  exp_rdata      err  lat psel
    vecs[0] = '{1'b1, 12'h008, 32'hA5A5_0001, 0, 1'b0, 0, 32'h0000_0000, 1'b0, 3, 2};
    vecs[1] = '{1'b0, 12'h004, 32'h0,         3, 1'b0, 0, 32'h0000_0123, 1'b0, 6, 5};
    vecs[2] = '{1'b0, 12'h00C, 32'h0,         0, 1'b1, 0, 32'h0000_0000, 1'b1, 3, 2};
    vecs[3] = '{1'b0, 12'h008, 32'h0,         0, 1'b0, 0, 32'hA5A5_0001, 1'b0, 3, 2};
    vecs[4] = '{1'b1, 12'h006, 32'h1234_5678, 0, 1'b0, 0, 32'h0000_0000, 1'b1, 1, 0};
    vecs[5] = '{1'b0, 12'h010, 32'h0,         0, 1'b0, 5, 32'h1000_0004, 1'b0, 3, 2};
    vecs[6] = '{1'b1, 12'h00C, 32'hDEAD_BEEF, 1, 1'b1, 0, 32'h0000_0000, 1'b1, 4, 3};
    vecs[7] = '{1'b0, 12'h00C, 32'h0,         2, 1'b0, 0, 32'h1000_0003, 1'b0, 5, 4};
    vecs[8] = '{1'b0, 12'h001, 32'h0,         0, 1'b0, 0, 32'h0000_0000, 1'b1, 1, 0};
    vecs[9] = '{1'b0, 12'hFFC, 32'h0,         0, 1'b0, 1, 32'h1000_03FF, 1'b0, 3, 2};

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;

    repeat (3) @(negedge PCLK);
    chk("rst_psel", 32'(bus.PSEL), 0);
    chk("rst_penable", 32'(bus.PENABLE), 0);
    chk("rst_pwrite", 32'(bus.PWRITE), 0);
    chk("rst_paddr", 32'(bus.PADDR), 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    PRESETn = 1'b1;

    have_prev = 0;
    prev_hs   = 0;
    for (int i = 0; i < NV; i++) begin
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].waits, vecs[i].serr, vecs[i].hold,
              rd, er, lat, np, ne, ac, hs);
      model(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].waits, vecs[i].serr,
            e_rd, e_err, e_lat, e_psel);
      chk($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("tbl%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("tbl%0d_psel_cycles", i), np, vecs[i].exp_psel);
      chk($sformatf("tbl%0d_penable_cycles", i), ne,
          (vecs[i].exp_psel == 0) ? 0 : vecs[i].exp_psel - 1);
      if (have_prev) chk($sformatf("tbl%0d_accept_gap", i), ac - prev_hs, 1);
      prev_hs   = hs;
      have_prev = 1;
    end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    run_cmd(1'b0, 12'h004, 32'h0, 10, 1'b0, 0, rd, er, lat, np, ne, ac, hs);
    chk("tmo_err", 32'(er), 1);
    chk("tmo_rdata", rd, 0);
    chk("tmo_latency", lat, 2 + TMO);
    chk("tmo_penable_cycles", ne, TMO);
`endif

    // Reset pulse in the middle of an ACCESS phase with the slave stalling.
    @(negedge PCLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 12'h008; bus.PREADY = 1'b0;
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("midrst_in_access", 32'(bus.PSEL & bus.PENABLE), 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_psel", 32'(bus.PSEL), 0);
    chk("midrst_penable", 32'(bus.PENABLE), 0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_paddr", 32'(bus.PADDR), 0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;

    have_prev = 0;
    for (int i = 0; i < 150; i++) begin
      logic        wr, serr;
      logic [11:0] addr;
      logic [31:0] wd;
      int unsigned waits, hold;
      wr    = 1'($urandom_range(0, 1));
      addr  = 12'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) addr = addr | 12'($urandom_range(1, 3));
      wd    = $urandom;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      waits = $urandom_range(0, 6);
`else
      waits = $urandom_range(0, 5);
`endif
      serr  = ($urandom_range(0, 5) == 0);
      hold  = $urandom_range(0, 2);
      run_cmd(wr, addr, wd, waits, serr, hold, rd, er, lat, np, ne, ac, hs);
      model(wr, addr, wd, waits, serr, e_rd, e_err, e_lat, e_psel);
      chk("rnd_rdata", rd, e_rd);
      chk("rnd_err", 32'(er), 32'(e_err));
      chk("rnd_latency", lat, e_lat);
      chk("rnd_psel_cycles", np, e_psel);
      chk("rnd_penable_cycles", ne, (e_psel == 0) ? 0 : e_psel - 1);
      if (have_prev) chk("rnd_accept_gap", ac - prev_hs, 1);
      prev_hs   = hs;
      have_prev = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
